pmt_uart_scheduler: RTL and testbench

Sequences the PMT time-bin count stream onto the UART transmitter. Per-bin PMT1/PMT2 counts are buffered in a small FIFO, formatted per the selected output mode (PMT1, PMT2, saturated sum, or both), and handed to the UART one frame at a time using the UART's `transmit`/`tx_Done` handshake. Start, stop and mode commands arrive as bytes from the UART receiver. Sits between the time-bin counter and `uart`.

---
 rtl/pmt_uart_pkg.sv | 41 ++++
 rtl/pmt_sample_fifo.sv | 58 +++++
 rtl/pmt_uart_scheduler.sv | 156 +++++++++++++++
 tb/tb_pmt_uart_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmt_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmt_uart_pkg
// Description : Shared constants, FSM state type and frame formatting helper
//               for the PMT-to-UART scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package pmt_uart_pkg;

  // Output mode encodings
  localparam logic [1:0] MODE_PMT1 = 2'd0;
  localparam logic [1:0] MODE_PMT2 = 2'd1;
  localparam logic [1:0] MODE_SUM  = 2'd2;
  localparam logic [1:0] MODE_BOTH = 2'd3;

  // Command bytes received from the UART
  localparam logic [7:0] CMD_START     = 8'h53;
  localparam logic [7:0] CMD_STOP      = 8'h58;
  localparam logic [7:0] CMD_MODE_BASE = 8'h30;

  // Transmit sequencing states
  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_WAIT_DONE = 1'b1
  } sched_state_t;

  // Returns {two_bytes, frame[15:0]} for a {pmt2, pmt1} sample.
  function automatic logic [16:0] format_frame(input logic [1:0]  mode,
                                               input logic [15:0] sample);
    logic [8:0] sum;
    sum = {1'b0, sample[7:0]} + {1'b0, sample[15:8]};
    case (mode)
      MODE_PMT1: format_frame = {1'b0, 8'h00, sample[7:0]};
      MODE_PMT2: format_frame = {1'b0, 8'h00, sample[15:8]};
      MODE_SUM:  format_frame = {1'b0, 8'h00, (sum[8] ? 8'hFF : sum[7:0])};
      default:   format_frame = {1'b1, sample};
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pmt_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pmt_sample_fifo
// Description : Synchronous 16-bit sample FIFO with flush. Pointers carry an
//               extra wrap bit so full and empty are distinguishable.
// Revision    : 1.0 - initial release
// ============================================================================
module pmt_sample_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [15:0]              din,
  output logic [15:0]              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_addr_w = $clog2(DEPTH);

  logic [15:0]       r_mem [DEPTH];
  logic [c_addr_w:0] r_wr_ptr;
  logic [c_addr_w:0] r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot this cycle
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                 (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
  assign level = r_wr_ptr - r_rd_ptr;
  assign dout  = r_mem[r_rd_ptr[c_addr_w-1:0]];

  // Pointer update; flush overrides any same-cycle push or pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_addr_w+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_addr_w+1)'(1);
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr[c_addr_w-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/pmt_uart_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pmt_uart_scheduler
// Description : Buffers per-bin PMT1/PMT2 counts, formats them by output mode
//               and hands one frame at a time to the UART transmitter.
//               Optional transmit watchdog enabled by macro TX_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pmt_uart_scheduler
  import pmt_uart_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bin_valid,
  input  logic [7:0]                   pmt1_count,
  input  logic [7:0]                   pmt2_count,
  input  logic                         rx_received,
  input  logic [7:0]                   rx_byte,
  input  logic                         tx_done,
  output logic                         uart_transmit,
  output logic [15:0]                  uart_tx_byte,
  output logic                         uart_two_bytes,
  output logic                         uart_stop,
  output logic                         running,
  output logic [1:0]                   mode,
  output logic                         overflow,
  output logic                         tx_timeout,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  sched_state_t r_state;
  logic         r_running;
  logic [1:0]   r_mode;
  logic         r_overflow;
  logic         r_transmit;
  logic [15:0]  r_tx_byte;
  logic         r_two_bytes;

  logic         w_cmd_start;
  logic         w_cmd_stop;
  logic         w_cmd_mode;
  logic         w_flush;
  logic         w_push_req;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [15:0]  w_dout;
  logic         w_wd_expire;

  assign w_cmd_start = rx_received && (rx_byte == CMD_START);
  assign w_cmd_stop  = rx_received && (rx_byte == CMD_STOP);
  assign w_cmd_mode  = rx_received && (rx_byte[7:2] == CMD_MODE_BASE[7:2]);
  assign w_flush     = w_cmd_start || w_cmd_stop;
  assign w_push_req  = bin_valid && r_running;
  assign w_pop       = (r_state == ST_IDLE) && r_running && !w_empty;

  pmt_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req && !w_flush),
    .pop   (w_pop),
    .flush (w_flush),
    .din   ({pmt2_count, pmt1_count}),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  // Command decode: run/stop, output mode, sticky overflow (start clears it)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_running  <= 1'b0;
      r_mode     <= MODE_PMT1;
      r_overflow <= 1'b0;
    end else begin
      if (w_cmd_start)     r_running <= 1'b1;
      else if (w_cmd_stop) r_running <= 1'b0;
      if (w_cmd_mode) r_mode <= rx_byte[1:0];
      if (w_cmd_start)
        r_overflow <= 1'b0;
      else if (w_push_req && w_full && !w_pop && !w_flush)
        r_overflow <= 1'b1;
    end
  end

  // Transmit FSM: pop and latch a formatted frame, then wait for end of frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_transmit  <= 1'b0;
      r_tx_byte   <= 16'h0000;
      r_two_bytes <= 1'b0;
    end else begin
      r_transmit <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            {r_two_bytes, r_tx_byte} <= format_frame(r_mode, w_dout);
            r_transmit               <= 1'b1;
            r_state                  <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_done || w_wd_expire) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef TX_WATCHDOG_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_cnt_w-1:0] r_wd_cnt;
  logic               r_tx_timeout;

  // Fires on the last of TIMEOUT_CYCLES consecutive WAIT_DONE cycles without tx_done
  assign w_wd_expire = (r_state == ST_WAIT_DONE) && !tx_done &&
                       (r_wd_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

  // Watchdog counter; held at zero outside WAIT_DONE so each frame starts fresh
  always_ff @(posedge clk) begin
    if (rst || r_state != ST_WAIT_DONE || tx_done || w_wd_expire)
      r_wd_cnt <= '0;
    else
      r_wd_cnt <= r_wd_cnt + c_cnt_w'(1);
  end

  // Sticky timeout flag, cleared by a start command
  always_ff @(posedge clk) begin
    if (rst)              r_tx_timeout <= 1'b0;
    else if (w_cmd_start) r_tx_timeout <= 1'b0;
    else if (w_wd_expire) r_tx_timeout <= 1'b1;
  end

  assign tx_timeout = r_tx_timeout;
`else
  assign w_wd_expire = 1'b0;
  // TIMEOUT_CYCLES only sizes the watchdog; the flag is constant zero here
  assign tx_timeout  = (TIMEOUT_CYCLES < 0);
`endif

  assign uart_transmit  = r_transmit;
  assign uart_tx_byte   = r_tx_byte;
  assign uart_two_bytes = r_two_bytes;
  assign running        = r_running;
  assign uart_stop      = ~r_running;
  assign mode           = r_mode;
  assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pmt_uart_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmt_uart_scheduler
// Description : Self-checking bench for pmt_uart_scheduler: queue-based
//               reference model compared every cycle, plus directed literal
//               checks. Watchdog scenario runs when TX_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pmt_uart_scheduler;

  localparam int DEPTH = 8;
  localparam int TO    = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bin_valid = 1'b0;
  logic [7:0]  pmt1_count = 8'h00;
  logic [7:0]  pmt2_count = 8'h00;
  logic        rx_received = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_done = 1'b0;
  logic        uart_transmit;
  logic [15:0] uart_tx_byte;
  logic        uart_two_bytes;
  logic        uart_stop;
  logic        running;
  logic [1:0]  mode;
  logic        overflow;
  logic        tx_timeout;
  logic [3:0]  fifo_level;

  pmt_uart_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .bin_valid      (bin_valid),
    .pmt1_count     (pmt1_count),
    .pmt2_count     (pmt2_count),
    .rx_received    (rx_received),
    .rx_byte        (rx_byte),
    .tx_done        (tx_done),
    .uart_transmit  (uart_transmit),
    .uart_tx_byte   (uart_tx_byte),
    .uart_two_bytes (uart_two_bytes),
    .uart_stop      (uart_stop),
    .running        (running),
    .mode           (mode),
    .overflow       (overflow),
    .tx_timeout     (tx_timeout),
    .fifo_level     (fifo_level)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_q[$];
  bit          m_run, m_busy, m_pulse, m_ovf, m_tmo, m_two;
  logic [1:0]  m_mode;
  logic [15:0] m_byte;
  int          m_wd;
  bit          model_live = 1'b0;
  bit          p_run, p_busy, p_full, p_pop, is_start, is_stop;
  logic [16:0] fr;

  function automatic logic [16:0] expect_frame(input logic [1:0] md, input logic [15:0] s);
    int sum;
    case (md)
      2'd0: return {9'h000, s[7:0]};
      2'd1: return {9'h000, s[15:8]};
      2'd2: begin
        sum = int'(s[7:0]) + int'(s[15:8]);
        if (sum > 255) sum = 255;
        return {9'h000, 8'(sum)};
      end
      default: return {1'b1, s};
    endcase
  endfunction

  always @(posedge clk) begin
    model_live = 1'b1;
    if (rst) begin
      m_q.delete();
      m_run = 0; m_busy = 0; m_pulse = 0; m_ovf = 0; m_tmo = 0; m_two = 0;
      m_mode = 2'd0; m_byte = 16'h0000; m_wd = 0;
    end else begin
      p_run    = m_run;
      p_busy   = m_busy;
      p_full   = (m_q.size() == DEPTH);
      p_pop    = !p_busy && p_run && (m_q.size() > 0);
      is_start = rx_received && (rx_byte == 8'h53);
      is_stop  = rx_received && (rx_byte == 8'h58);
      m_pulse  = 0;
      if (p_busy) begin
        if (tx_done) m_busy = 0;
`ifdef TX_WATCHDOG_EN
        else if (m_wd == TO - 1) begin m_busy = 0; m_tmo = 1; end
        else m_wd++;
`endif
      end else if (p_pop) begin
        fr = expect_frame(m_mode, m_q.pop_front());
        m_two = fr[16]; m_byte = fr[15:0];
        m_pulse = 1; m_busy = 1; m_wd = 0;
      end
      if (bin_valid && p_run && !(is_start || is_stop)) begin
        if (!p_full || p_pop) m_q.push_back({pmt2_count, pmt1_count});
        else m_ovf = 1;
      end
      if (is_start || is_stop) m_q.delete();
      if (is_start) begin m_run = 1; m_ovf = 0; m_tmo = 0; end
      if (is_stop) m_run = 0;
      if (rx_received && rx_byte >= 8'h30 && rx_byte <= 8'h33) m_mode = rx_byte[1:0];
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (model_live) begin
      chk("m_transmit",  32'(uart_transmit),  32'(m_pulse));
      chk("m_tx_byte",   32'(uart_tx_byte),   32'(m_byte));
      chk("m_two_bytes", 32'(uart_two_bytes), 32'(m_two));
      chk("m_running",   32'(running),        32'(m_run));
      chk("m_uart_stop", 32'(uart_stop),      32'(!m_run));
      chk("m_mode",      32'(mode),           32'(m_mode));
      chk("m_overflow",  32'(overflow),       32'(m_ovf));
      chk("m_timeout",   32'(tx_timeout),     32'(m_tmo));
      chk("m_level",     32'(fifo_level),     32'(m_q.size()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_received = 1'b1; rx_byte = b; tick(); rx_received = 1'b0;
  endtask

  task automatic bin(input logic [7:0] p1, input logic [7:0] p2);
    bin_valid = 1'b1; pmt1_count = p1; pmt2_count = p2; tick(); bin_valid = 1'b0;
  endtask

  task automatic done();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
  endtask

  task automatic wait_tx(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (uart_transmit) seen = 1;
      else tick();
    end
    chk({name, "_tx_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_transmit", 32'(uart_transmit), 32'd0);
    chk("rst_stop",     32'(uart_stop),     32'd1);
    chk("rst_level",    32'(fifo_level),    32'd0);
    chk("rst_byte",     32'(uart_tx_byte),  32'd0);

    // Basic latency, mode 0
    send_cmd(8'h53);
    send_cmd(8'h30);
    chk("start_running", 32'(running), 32'd1);
    bin(8'h12, 8'h34);
    chk("lat_n1", 32'(uart_transmit), 32'd0);
    tick();
    chk("lat_n2",      32'(uart_transmit),  32'd1);
    chk("pmt1_byte",   32'(uart_tx_byte),   32'h0012);
    chk("pmt1_two",    32'(uart_two_bytes), 32'd0);
    tick();
    chk("lat_n3", 32'(uart_transmit), 32'd0);
    done();

    // Saturated sum and two-byte mode
    send_cmd(8'h32);
    bin(8'd200, 8'd100); wait_tx("sum_sat"); chk("sum_sat", 32'(uart_tx_byte), 32'h00FF); done();
    bin(8'd10, 8'd20);   wait_tx("sum");     chk("sum",     32'(uart_tx_byte), 32'h001E); done();
    send_cmd(8'h33);
    bin(8'h12, 8'h34); wait_tx("both");
    chk("both_byte", 32'(uart_tx_byte),   32'h3412);
    chk("both_two",  32'(uart_two_bytes), 32'd1);
    done();

    // Overflow while a frame is held, then ordered drain
    bin(8'h01, 8'h00); wait_tx("ovf_first");
    for (int i = 0; i <= DEPTH; i++) bin(8'(8'h10 + i), 8'(i));
    chk("ovf_level", 32'(fifo_level), 32'(DEPTH));
    chk("ovf_flag",  32'(overflow),   32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      done();
      wait_tx("drain");
      chk("drain_order", 32'(uart_tx_byte), 32'({8'(i), 8'(8'h10 + i)}));
    end
    done();

    // Stop mid-frame
    bin(8'h05, 8'h06); wait_tx("stop_frame");
    bin(8'h07, 8'h08);
    send_cmd(8'h58);
    chk("stop_running", 32'(running),    32'd0);
    chk("stop_uart",    32'(uart_stop),  32'd1);
    chk("stop_level",   32'(fifo_level), 32'd0);
    chk("stop_ovf",     32'(overflow),   32'd1);
    repeat (3) tick();
    done();
    repeat (3) tick();
    chk("stop_no_pop", 32'(uart_transmit), 32'd0);
    send_cmd(8'h53);
    chk("restart_ovf", 32'(overflow), 32'd0);

    // Mode change during WAIT_DONE, ignored byte
    send_cmd(8'h30);
    bin(8'h21, 8'h43); wait_tx("mchg");
    send_cmd(8'h31);
    chk("mchg_hold", 32'(uart_tx_byte), 32'h0021);
    chk("mchg_mode", 32'(mode),         32'd1);
    done();
    bin(8'h22, 8'h44); wait_tx("mchg_next");
    chk("mchg_next", 32'(uart_tx_byte), 32'h0044);
    send_cmd(8'h41);
    chk("ignore_mode", 32'(mode),    32'd1);
    chk("ignore_run",  32'(running), 32'd1);
    done();

    // Push and pop together while full; flush beats push
    bin(8'h09, 8'h09); wait_tx("full_first");
    for (int i = 0; i < DEPTH; i++) bin(8'(i), 8'h00);
    chk("full_level", 32'(fifo_level), 32'(DEPTH));
    done();
    bin(8'h77, 8'h66);
    chk("pp_level",    32'(fifo_level),    32'(DEPTH));
    chk("pp_ovf",      32'(overflow),      32'd0);
    chk("pp_transmit", 32'(uart_transmit), 32'd1);
    rx_received = 1'b1; rx_byte = 8'h58; bin_valid = 1'b1;
    tick();
    rx_received = 1'b0; bin_valid = 1'b0;
    chk("flush_push_level", 32'(fifo_level), 32'd0);
    done();

    // Reset in the middle of a frame
    send_cmd(8'h53);
    bin(8'h01, 8'h02); wait_tx("rst_mid");
    rst = 1'b1; tick();
    chk("rstm_transmit", 32'(uart_transmit), 32'd0);
    chk("rstm_byte",     32'(uart_tx_byte),  32'd0);
    chk("rstm_running",  32'(running),       32'd0);
    chk("rstm_stop",     32'(uart_stop),     32'd1);
    chk("rstm_level",    32'(fifo_level),    32'd0);
    rst = 1'b0; tick();

`ifdef TX_WATCHDOG_EN
    send_cmd(8'h53);
    send_cmd(8'h30);
    bin(8'h03, 8'h00);
    bin(8'h04, 8'h00);
    wait_tx("wd");
    repeat (TO - 1) tick();
    chk("wd_before", 32'(tx_timeout), 32'd0);
    tick();
    chk("wd_fire", 32'(tx_timeout), 32'd1);
    tick();
    chk("wd_next_tx",   32'(uart_transmit), 32'd1);
    chk("wd_next_byte", 32'(uart_tx_byte),  32'h0004);
    done();
    send_cmd(8'h53);
    chk("wd_clear", 32'(tx_timeout), 32'd0);
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
